exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 3, number of cycles pipeline flush is held before redirect (legal 1..15).
REQ-002 Parameter: EXC_VECTOR, default 32'hBFC00380, exception entry PC (BEV fixed at 1).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 commit_valid  in  1  instruction present at commit stage.
REQ-006 commit_ready  out  1  controller can accept a commit-stage event.
REQ-007 commit_pc  in  32  PC of committing instruction.
REQ-008 commit_bd  in  1  committing instruction is in a delay slot.
REQ-009 commit_exc  in  6  flags {if_adel, ri, ov, sys, bp, mem_ade}; mem_ade qualified by commit_store.
REQ-010 commit_store  in  1  mem_ade is a store (AdES) rather than load (AdEL).
REQ-011 commit_eret  in  1  committing instruction is ERET.
REQ-012 commit_badvaddr  in  32  faulting data address; fetch faults use commit_pc.
REQ-013 status_ie, status_exl  in  1 each  CP0 Status bits; status_im, cause_ip  in  8 each.
REQ-014 epc  in  32  CP0 EPC, ERET target.
REQ-015 cp0_exception, cp0_eret  out  1 each  single-cycle strobes to CP0.
REQ-016 cp0_excode  out  5; cp0_pc  out  32; cp0_bd  out  1; cp0_badvaddr  out  32  CP0 update payload.
REQ-017 flush  out  1  kill all in-flight instructions.
REQ-018 redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1  fetch redirect handshake.

Function
REQ-019 int_pending SHALL be status_ie & ~status_exl & |(status_im & cause_ip).
REQ-020 An event SHALL be accepted only when commit_valid & commit_ready & (int_pending | |commit_exc | commit_eret).
REQ-021 Priority, highest first: interrupt (0x00), if_adel (0x04), ri (0x0A), ov (0x0C), sys (0x08), bp (0x09), mem_ade (0x04 load / 0x05 store).
REQ-022 Any interrupt or exception SHALL override a simultaneous commit_eret; ERET is then not performed.
REQ-023 badvaddr SHALL be commit_pc for if_adel, commit_badvaddr for mem_ade, unchanged-don't-care otherwise.
REQ-024 FSM states IDLE, FLUSH, REDIRECT; commit_ready=1 only in IDLE.
REQ-025 IDLE->FLUSH on accept; payload, target and kind SHALL be latched at the accepting edge.
REQ-026 First FLUSH cycle: exactly one of cp0_exception/cp0_eret SHALL be 1 for exactly one cycle; payload outputs stable that cycle.
REQ-027 flush SHALL be 1 in every FLUSH and REDIRECT cycle, 0 in IDLE.
REQ-028 FLUSH SHALL last exactly FLUSH_CYCLES cycles (4-bit down-counter), then ->REDIRECT.
REQ-029 redirect_pc SHALL be EXC_VECTOR for exceptions/interrupts, epc sampled on the accepting cycle for ERET.
REQ-030 REDIRECT: redirect_valid=1 and redirect_pc held constant until redirect_ready; transfer cycle ->IDLE.
REQ-031 Events presented while not IDLE SHALL be ignored (upstream holds them via commit_ready=0).
REQ-032 With status_exl=1, interrupts SHALL be masked; synchronous exceptions still accepted (CP0 preserves EPC).
REQ-033 Back-to-back: an event presented the cycle after REDIRECT->IDLE SHALL be accepted normally.

Reset
REQ-034 On resetn=0, asynchronously: state=IDLE, counter=0, all strobes, flush, redirect_valid=0, payload registers 0.
REQ-035 Reset mid-FLUSH/REDIRECT SHALL abort the sequence with no further strobe or redirect.

Structure
REQ-036 Excode constants and FSM state encodings SHALL live in the shared cp0 header/package.
REQ-037 Priority encoder SHALL be a sub-module exc_prio (combinational: flags+int_pending -> excode, valid).

Verification
REQ-038 commit_exc=ov, pc=0x80001000, bd=0 -> next cycle cp0_exception=1, excode 0x0C, cp0_pc 0x80001000; flush 3 cycles; redirect_pc 0xBFC00380.
REQ-039 int_pending=1 with ri and eret asserted -> excode 0x00, cp0_eret never asserted.
REQ-040 ERET, epc=0x80002004 -> cp0_eret single pulse, redirect_pc 0x80002004.
REQ-041 Store to 0x1003 with mem_ade, commit_store=1 -> excode 0x05, cp0_badvaddr 0x00001003.
REQ-042 redirect_ready low 5 cycles -> redirect_valid, redirect_pc, flush stable; commit_ready 0 throughout.
REQ-043 resetn low during FLUSH cycle 2 -> all outputs 0 immediately; no redirect after release.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller.
// Holds the CP0 exception codes, the controller FSM state encoding, the
// badvaddr source select used between the priority encoder and the top, and
// the interrupt-pending helper.
package exc_ctrl_pkg;

  // Bit positions inside commit_exc = {if_adel, ri, ov, sys, bp, mem_ade}
  localparam int EXC_FLAG_W    = 6;
  localparam int FLAG_IF_ADEL  = 5;
  localparam int FLAG_RI       = 4;
  localparam int FLAG_OV       = 3;
  localparam int FLAG_SYS      = 2;
  localparam int FLAG_BP       = 1;
  localparam int FLAG_MEM_ADE  = 0;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } excode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  // Where cp0_badvaddr is taken from for the winning cause
  typedef enum logic [1:0] {
    BV_KEEP = 2'd0,
    BV_PC   = 2'd1,
    BV_DATA = 2'd2
  } bv_sel_e;

  function automatic logic int_pending_f(input logic       ie,
                                         input logic       exl,
                                         input logic [7:0] im,
                                         input logic [7:0] ip);
    return ie & ~exl & (|(im & ip));
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Commit-stage and fetch-redirect handshakes of the exception controller.
//   commit_*   : pipeline commit stage -> controller (commit_ready back)
//   redirect_* : controller -> fetch (redirect_ready back)
// master = pipeline side, slave = exception controller.
interface exc_ctrl_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [5:0]  commit_exc;
  logic        commit_store;
  logic        commit_eret;
  logic [31:0] commit_badvaddr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output commit_valid, commit_pc, commit_bd, commit_exc, commit_store,
           commit_eret, commit_badvaddr, redirect_ready,
    input  commit_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_bd, commit_exc, commit_store,
           commit_eret, commit_badvaddr, redirect_ready,
    output commit_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_prio.sv
// Combinational exception priority encoder.
// Ports:
//   int_pending in  1  unmasked interrupt pending
//   flags       in  6  {if_adel, ri, ov, sys, bp, mem_ade}
//   is_store    in  1  mem_ade is a store (AdES) instead of a load (AdEL)
//   excode      out 5  code of the highest-priority cause
//   valid       out 1  some interrupt/exception is present
//   bv_sel      out 2  badvaddr source for the winning cause
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic                  int_pending,
  input  logic [EXC_FLAG_W-1:0] flags,
  input  logic                  is_store,
  output logic [4:0]            excode,
  output logic                  valid,
  output bv_sel_e               bv_sel
);

  always_comb begin
    excode = EXC_INT;
    valid  = 1'b1;
    bv_sel = BV_KEEP;
    if (int_pending) begin
      excode = EXC_INT;
    end else if (flags[FLAG_IF_ADEL]) begin
      excode = EXC_ADEL;
      bv_sel = BV_PC;
    end else if (flags[FLAG_RI]) begin
      excode = EXC_RI;
    end else if (flags[FLAG_OV]) begin
      excode = EXC_OV;
    end else if (flags[FLAG_SYS]) begin
      excode = EXC_SYS;
    end else if (flags[FLAG_BP]) begin
      excode = EXC_BP;
    end else if (flags[FLAG_MEM_ADE]) begin
      excode = is_store ? EXC_ADES : EXC_ADEL;
      bv_sel = BV_DATA;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / ERET controller at the commit stage.
// Accepts an interrupt, exception or ERET from commit, strobes CP0 once,
// flushes the pipeline for FLUSH_CYCLES cycles and then redirects fetch to
// the exception vector or to EPC.
// Ports:
//   clk, resetn          clock, async active-low reset
//   bus (slave)          commit handshake + fetch redirect handshake
//   status_ie/exl/im     CP0 Status bits, cause_ip CP0 Cause.IP
//   epc                  CP0 EPC (ERET target, sampled at accept)
//   cp0_exception/eret   single-cycle strobes to CP0
//   cp0_excode/pc/bd/badvaddr  CP0 update payload
//   flush                kill in-flight instructions
//
// state       | meaning
// ST_IDLE     | waiting for an event, commit_ready=1
// ST_FLUSH    | strobe on first cycle, flush held FLUSH_CYCLES cycles
// ST_REDIRECT | redirect_valid held until redirect_ready
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 3,   // legal 1..15
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  exc_ctrl_if.slave   bus,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic [31:0] epc,
  output logic        cp0_exception,
  output logic        cp0_eret,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_pc,
  output logic        cp0_bd,
  output logic [31:0] cp0_badvaddr,
  output logic        flush
);

  exc_state_e  state;
  logic [3:0]  cnt;
  logic        commit_ready_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic        cp0_exception_q;
  logic        cp0_eret_q;
  logic [4:0]  cp0_excode_q;
  logic [31:0] cp0_pc_q;
  logic        cp0_bd_q;
  logic [31:0] cp0_badvaddr_q;
  logic        flush_q;

  logic        int_pending;
  logic [4:0]  prio_code;
  logic        prio_valid;
  bv_sel_e     prio_bv_sel;
  logic        accept;

  assign int_pending = int_pending_f(status_ie, status_exl, status_im, cause_ip);

  exc_prio u_prio (
    .int_pending (int_pending),
    .flags       (bus.commit_exc),
    .is_store    (bus.commit_store),
    .excode      (prio_code),
    .valid       (prio_valid),
    .bv_sel      (prio_bv_sel)
  );

  assign accept = bus.commit_valid & commit_ready_q &
                  (int_pending | (|bus.commit_exc) | bus.commit_eret);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      commit_ready_q   <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cp0_exception_q  <= 1'b0;
      cp0_eret_q       <= 1'b0;
      cp0_excode_q     <= '0;
      cp0_pc_q         <= '0;
      cp0_bd_q         <= 1'b0;
      cp0_badvaddr_q   <= '0;
      flush_q          <= 1'b0;
    end else begin
      // strobes are one cycle wide by construction
      cp0_exception_q <= 1'b0;
      cp0_eret_q      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state          <= ST_FLUSH;
            cnt            <= 4'(FLUSH_CYCLES - 1);
            commit_ready_q <= 1'b0;
            flush_q        <= 1'b1;
            if (prio_valid) begin
              // exception/interrupt wins over a simultaneous ERET
              cp0_exception_q <= 1'b1;
              cp0_excode_q    <= prio_code;
              cp0_pc_q        <= bus.commit_pc;
              cp0_bd_q        <= bus.commit_bd;
              redirect_pc_q   <= EXC_VECTOR;
              case (prio_bv_sel)
                BV_PC:   cp0_badvaddr_q <= bus.commit_pc;
                BV_DATA: cp0_badvaddr_q <= bus.commit_badvaddr;
                default: cp0_badvaddr_q <= cp0_badvaddr_q;
              endcase
            end else begin
              cp0_eret_q    <= 1'b1;
              redirect_pc_q <= epc;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt == 4'd0) begin
            state            <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            state            <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            commit_ready_q   <= 1'b1;
          end
        end
        default: begin
          state            <= ST_IDLE;
          cnt              <= '0;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
          commit_ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.commit_ready   = commit_ready_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign cp0_exception      = cp0_exception_q;
  assign cp0_eret           = cp0_eret_q;
  assign cp0_excode         = cp0_excode_q;
  assign cp0_pc             = cp0_pc_q;
  assign cp0_bd             = cp0_bd_q;
  assign cp0_badvaddr       = cp0_badvaddr_q;
  assign flush              = flush_q;

endmodule
